sram_controller: RTL

SRAM_CONTROLLER -- requirements
Module: sram_controller

---
 rtl/sram_controller.sv | 137 +++++++++++++
 1 files changed

// File: rtl/sram_controller.sv
// Bridges a 32-bit pipeline load/store port onto a 16-bit asynchronous SRAM,
// splitting each word into a low and a high half-word access.
module sram_controller #(
  parameter logic [31:0] DATA_BASE  = 32'd1024,
  parameter int unsigned PHASE_WAIT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic        rd_en,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        ready,
  inout  wire  [15:0] SRAM_DQ,
  output logic [17:0] SRAM_ADDR,
  output logic        SRAM_WE_N,
  output logic        SRAM_OE_N,
  output logic        SRAM_CE_N,
  output logic        SRAM_UB_N,
  output logic        SRAM_LB_N
);

  localparam int unsigned CNT_W = 3;
  localparam int unsigned IDX_W = 17;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PHASE_WAIT - 1);

  typedef enum logic [2:0] {IDLE, WR_LO, WR_HI, RD_LO, RD_HI, DONE} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [31:0]        rdata_q, rdata_d;
  logic [17:0]        addr_q, addr_d;
  logic               we_n_q, we_n_d;
  logic               oe_n_q, oe_n_d;
  logic               dq_oe_q, dq_oe_d;
  logic [15:0]        dq_out_q, dq_out_d;
  logic [IDX_W-1:0]   idx_in;
  logic               phase_last;
  logic               in_phase;

  // Word index within the SRAM window; upper bits wrap silently.
  assign idx_in     = IDX_W'((address - DATA_BASE) >> 2);
  assign phase_last = (cnt_q == CNT_LAST);
  assign in_phase   = (state_q == WR_LO) || (state_q == WR_HI) ||
                      (state_q == RD_LO) || (state_q == RD_HI);

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    addr_d   = addr_q;
    cnt_d    = '0;
    unique case (state_q)
      IDLE: begin
        if (wr_en) begin
          state_d = WR_LO;
          idx_d   = idx_in;
          wdata_d = write_data;
        end else if (rd_en) begin
          state_d = RD_LO;
          idx_d   = idx_in;
        end
      end
      WR_LO: if (phase_last) state_d = WR_HI;
      WR_HI: if (phase_last) state_d = DONE;
      RD_LO: begin
        if (phase_last) begin
          state_d       = RD_HI;
          rdata_d[15:0] = SRAM_DQ;
        end
      end
      RD_HI: begin
        if (phase_last) begin
          state_d        = DONE;
          rdata_d[31:16] = SRAM_DQ;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (in_phase && !phase_last) cnt_d = cnt_q + CNT_W'(1);

    // Address register only moves when a new half-word phase begins.
    if (state_q == IDLE && (state_d == WR_LO || state_d == RD_LO))
      addr_d = {idx_d, 1'b0};
    else if (state_d != state_q && (state_d == WR_HI || state_d == RD_HI))
      addr_d = {idx_q, 1'b1};

    we_n_d   = !(state_d == WR_LO || state_d == WR_HI);
    oe_n_d   = !(state_d == RD_LO || state_d == RD_HI);
    dq_oe_d  = !we_n_d;
    dq_out_d = (state_d == WR_HI) ? wdata_d[31:16] : wdata_d[15:0];

    ready = ((state_q == IDLE) && !(wr_en || rd_en)) || (state_q == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      addr_q   <= '0;
      we_n_q   <= 1'b1;
      oe_n_q   <= 1'b1;
      dq_oe_q  <= 1'b0;
      dq_out_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      addr_q   <= addr_d;
      we_n_q   <= we_n_d;
      oe_n_q   <= oe_n_d;
      dq_oe_q  <= dq_oe_d;
      dq_out_q <= dq_out_d;
    end
  end

  assign SRAM_DQ   = dq_oe_q ? dq_out_q : 16'hzzzz;
  assign read_data = rdata_q;
  assign SRAM_ADDR = addr_q;
  assign SRAM_WE_N = we_n_q;
  assign SRAM_OE_N = oe_n_q;
  assign SRAM_CE_N = 1'b0;
  assign SRAM_UB_N = 1'b0;
  assign SRAM_LB_N = 1'b0;

endmodule
